nco8m: RTL and testbench

NCO8M -- requirements
Module: nco8m

---
 rtl/nco8m.sv | 275 +++++++++++++++++++++++++++
 tb/tb_nco8m.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/nco8m.sv
// -----------------------------------------------------------------------------
// nco8m -- 32-bit phase-accumulator NCO with a quarter-wave sine table.
//
// A 32-bit accumulator advances by phi_inc_i on every enabled clock. The top
// 12 bits of the phase select a quadrant and a 10-bit index into a 1025-entry
// quarter-wave magnitude table M[k] = round(511*sin(pi*k/2048)). Mirroring and
// negation rebuild the full wave in the range -511..+511 (-512 never appears).
//
// Pipeline (four registers between an accumulator value and fsin_o):
//   1 accumulate     : acc advances, the current acc phase is captured
//   2 address/quad   : table address (i or 1024-i) and output sign
//   3 table read     : magnitude from the quarter-wave table
//   4 sign/output    : signed sample and out_valid
// The first valid sample is the one for acc = 0.
//
// Ports
//   clk        in   1   sole clock, rising edge
//   reset_n    in   1   synchronous reset, ACTIVE HIGH despite its name
//   clken      in   1   clock enable; 0 freezes every register
//   phi_inc_i  in  32   unsigned phase increment, sampled each enabled cycle
//   fsin_o     out 10   two's-complement sine sample (registered)
//   fcos_o     out 10   two's-complement cosine sample (registered), only
//                       present when NCO8M_COS_OUT_EN is defined
//   out_valid  out  1   fsin_o (and fcos_o) hold a valid sample
//
// Build option
//   NCO8M_COS_OUT_EN : adds the fcos_o output and its second table read path.
//                      fsin_o is identical in both builds.
// -----------------------------------------------------------------------------
module nco8m (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clken,
    input  logic [31:0] phi_inc_i,
    output logic [9:0]  fsin_o,
`ifdef NCO8M_COS_OUT_EN
    output logic [9:0]  fcos_o,
`endif
    output logic        out_valid
);

    // pi scaled by 2^30, used by the elaboration-time table builder.
    localparam longint PI_Q30 = 64'sd3373259426;

    // Quarter-wave table entry round(511*sin(pi*k/2048)), evaluated only at
    // elaboration. Integer Q30 Taylor series (terms through x^19) keeps the
    // table free of real arithmetic; the residual error is around 1e-6 LSB,
    // far below the rounding step.
    function automatic logic [8:0] quarter_sine(input int k);
        longint x;
        longint x2;
        longint term;
        longint sum;
        longint mag;
        x    = (PI_Q30 * longint'(k)) >>> 7'd11;
        x2   = (x * x) >>> 7'd30;
        term = x;
        sum  = x;
        for (int n = 32'sd1; n <= 32'sd9; n++) begin
            term = ((term * x2) >>> 7'd30)
                   / longint'((32'sd2 * n) * (32'sd2 * n + 32'sd1));
            if (n[0]) begin
                sum = sum - term;
            end else begin
                sum = sum + term;
            end
        end
        mag = (64'sd511 * sum + (64'sd1 <<< 7'd29)) >>> 7'd30;
        return mag[8:0];
    endfunction

    // Quarter-wave magnitude ROM, 1025 constant entries.
    logic [8:0] mag_rom_s [0:1024];

    for (genvar k = 0; k <= 1024; k++) begin : g_rom
        localparam logic [8:0] MAG_K = quarter_sine(k);
        assign mag_rom_s[k] = MAG_K;
    end

    // ---------------------------------------------------------------- state
    logic [31:0] acc_r;        // phase accumulator
    logic [11:0] phase_r;      // stage 1: captured 12-bit phase
    logic        v1_r;
    logic [10:0] sin_addr_r;   // stage 2: table address for the sine
    logic        sin_neg_r;
    logic        v2_r;
    logic [8:0]  sin_mag_r;    // stage 3: sine magnitude
    logic        sin_neg3_r;
    logic        v3_r;

    // ----------------------------------------------------------- combinational
    logic [1:0]  quad_s;
    logic [9:0]  idx_s;
    logic [10:0] sin_addr_s;
    logic        sin_neg_s;
    logic [9:0]  fsin_s;

    // Stage-2 decode: quadrants 1 and 3 run the table backwards, 2 and 3 are
    // negative. Address 1024-i reaches M[1024] when i = 0, hence 11 bits.
    always_comb begin
        quad_s     = phase_r[11:10];
        idx_s      = phase_r[9:0];
        sin_addr_s = {1'b0, idx_s};
        sin_neg_s  = 1'b0;
        case (quad_s)
            2'd0: begin
                sin_addr_s = {1'b0, idx_s};
                sin_neg_s  = 1'b0;
            end
            2'd1: begin
                sin_addr_s = 11'd1024 - {1'b0, idx_s};
                sin_neg_s  = 1'b0;
            end
            2'd2: begin
                sin_addr_s = {1'b0, idx_s};
                sin_neg_s  = 1'b1;
            end
            2'd3: begin
                sin_addr_s = 11'd1024 - {1'b0, idx_s};
                sin_neg_s  = 1'b1;
            end
            default: begin
                sin_addr_s = {1'b0, idx_s};
                sin_neg_s  = 1'b0;
            end
        endcase
    end

    // Stage-4 sign application; magnitude never exceeds 511 so -512 cannot occur.
    always_comb begin
        if (sin_neg3_r) begin
            fsin_s = 10'd0 - {1'b0, sin_mag_r};
        end else begin
            fsin_s = {1'b0, sin_mag_r};
        end
    end

    // Accumulator and stage 1: capture the current phase, then advance acc.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            acc_r   <= 32'd0;
            phase_r <= 12'd0;
            v1_r    <= 1'b0;
        end else if (clken) begin
            acc_r   <= acc_r + phi_inc_i;
            phase_r <= acc_r[31:20];
            v1_r    <= 1'b1;
        end else begin
            acc_r   <= acc_r;
            phase_r <= phase_r;
            v1_r    <= v1_r;
        end
    end

    // Stage 2: register table address and sign.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            sin_addr_r <= 11'd0;
            sin_neg_r  <= 1'b0;
            v2_r       <= 1'b0;
        end else if (clken) begin
            sin_addr_r <= sin_addr_s;
            sin_neg_r  <= sin_neg_s;
            v2_r       <= v1_r;
        end else begin
            sin_addr_r <= sin_addr_r;
            sin_neg_r  <= sin_neg_r;
            v2_r       <= v2_r;
        end
    end

    // Stage 3: quarter-wave table read.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            sin_mag_r  <= 9'd0;
            sin_neg3_r <= 1'b0;
            v3_r       <= 1'b0;
        end else if (clken) begin
            sin_mag_r  <= mag_rom_s[sin_addr_r];
            sin_neg3_r <= sin_neg_r;
            v3_r       <= v2_r;
        end else begin
            sin_mag_r  <= sin_mag_r;
            sin_neg3_r <= sin_neg3_r;
            v3_r       <= v3_r;
        end
    end

    // Stage 4: registered signed sample and validity flag.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            fsin_o    <= 10'd0;
            out_valid <= 1'b0;
        end else if (clken) begin
            fsin_o    <= fsin_s;
            out_valid <= v3_r;
        end else begin
            fsin_o    <= fsin_o;
            out_valid <= out_valid;
        end
    end

`ifdef NCO8M_COS_OUT_EN
    // ------------------------------------------------------- cosine path
    logic [10:0] cos_addr_s;
    logic        cos_neg_s;
    logic [10:0] cos_addr_r;
    logic        cos_neg_r;
    logic [8:0]  cos_mag_r;
    logic        cos_neg3_r;
    logic [9:0]  fcos_s;

    // Cosine decode: the table direction is the mirror of the sine, and the
    // negative half is quadrants 1 and 2.
    always_comb begin
        cos_addr_s = 11'd1024 - {1'b0, idx_s};
        cos_neg_s  = 1'b0;
        case (quad_s)
            2'd0: begin
                cos_addr_s = 11'd1024 - {1'b0, idx_s};
                cos_neg_s  = 1'b0;
            end
            2'd1: begin
                cos_addr_s = {1'b0, idx_s};
                cos_neg_s  = 1'b1;
            end
            2'd2: begin
                cos_addr_s = 11'd1024 - {1'b0, idx_s};
                cos_neg_s  = 1'b1;
            end
            2'd3: begin
                cos_addr_s = {1'b0, idx_s};
                cos_neg_s  = 1'b0;
            end
            default: begin
                cos_addr_s = 11'd1024 - {1'b0, idx_s};
                cos_neg_s  = 1'b0;
            end
        endcase
    end

    // Cosine sign application.
    always_comb begin
        if (cos_neg3_r) begin
            fcos_s = 10'd0 - {1'b0, cos_mag_r};
        end else begin
            fcos_s = {1'b0, cos_mag_r};
        end
    end

    // Cosine stages 2..4, lock-step with the sine pipeline.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            cos_addr_r <= 11'd0;
            cos_neg_r  <= 1'b0;
            cos_mag_r  <= 9'd0;
            cos_neg3_r <= 1'b0;
            fcos_o     <= 10'd0;
        end else if (clken) begin
            cos_addr_r <= cos_addr_s;
            cos_neg_r  <= cos_neg_s;
            cos_mag_r  <= mag_rom_s[cos_addr_r];
            cos_neg3_r <= cos_neg_r;
            fcos_o     <= fcos_s;
        end else begin
            cos_addr_r <= cos_addr_r;
            cos_neg_r  <= cos_neg_r;
            cos_mag_r  <= cos_mag_r;
            cos_neg3_r <= cos_neg3_r;
            fcos_o     <= fcos_o;
        end
    end
`endif

endmodule

// File: tb/tb_nco8m.sv
`timescale 1ns/10ps
// -----------------------------------------------------------------------------
// tb_nco8m -- self-checking bench for nco8m.
// The reference keeps the ideal accumulator history and computes each sample
// from the phase with a real-valued sine table, then expects it four enabled
// edges later. Define NCO8M_COS_OUT_EN for both files to check fcos_o too.
// -----------------------------------------------------------------------------
module tb_nco8m;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clken;
    logic [31:0] phi_inc_i;
    logic [9:0]  fsin_o;
    logic        out_valid;
`ifdef NCO8M_COS_OUT_EN
    logic [9:0]  fcos_o;
`endif

    nco8m dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clken     (clken),
        .phi_inc_i (phi_inc_i),
        .fsin_o    (fsin_o),
`ifdef NCO8M_COS_OUT_EN
        .fcos_o    (fcos_o),
`endif
        .out_valid (out_valid)
    );

    // 20.16 ns period
    always #10.08 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          mag_tbl [0:1024];
    bit [31:0]   acc_q [$];
    bit [31:0]   model_acc;
    int          exp_sin;
    int          exp_cos;
    int          exp_valid;
    string       phase;

    task automatic check_val(input string tag, input int obs, input int exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s/%s: got %0d, expected %0d", phase, tag, obs, exp);
        end
    endtask

    function automatic int sin_of(input bit [31:0] a);
        int p, q, i, m;
        p = int'(a[31:20]);
        q = p / 1024;
        i = p % 1024;
        m = (q == 0 || q == 2) ? mag_tbl[i] : mag_tbl[1024 - i];
        return (q >= 2) ? -m : m;
    endfunction

    function automatic int cos_of(input bit [31:0] a);
        int p, q, i, m;
        p = int'(a[31:20]);
        q = p / 1024;
        i = p % 1024;
        m = (q == 0 || q == 2) ? mag_tbl[1024 - i] : mag_tbl[i];
        return (q == 1 || q == 2) ? -m : m;
    endfunction

    // One clock edge with the given inputs, then model update and output check.
    task automatic step(input bit rst, input bit en, input bit [31:0] inc);
        bit [31:0] a;
        reset_n   = rst;
        clken     = en;
        phi_inc_i = inc;
        @(posedge clk);
        #1;
        if (rst) begin
            acc_q.delete();
            model_acc = 32'd0;
            exp_sin   = 0;
            exp_cos   = 0;
            exp_valid = 0;
        end else if (en) begin
            acc_q.push_back(model_acc);
            model_acc = model_acc + inc;
            if (acc_q.size() >= 4) begin
                a         = acc_q.pop_front();
                exp_sin   = sin_of(a);
                exp_cos   = cos_of(a);
                exp_valid = 1;
            end
        end
        check_val("out_valid", int'(out_valid), exp_valid);
        check_val("fsin", int'($signed(fsin_o)), exp_sin);
`ifdef NCO8M_COS_OUT_EN
        check_val("fcos", int'($signed(fcos_o)), exp_cos);
`endif
    endtask

    initial begin
        int first_valid;
        int nvalid;
        int pmax;
        int pmin;
        int quarter_sin [4];
        int quarter_cos [4];
        bit [31:0] inc;

        quarter_sin = '{0, 511, 0, -511};
        quarter_cos = '{511, 0, -511, 0};
        for (int k = 0; k <= 1024; k++) begin
            mag_tbl[k] = $rtoi(511.0 * $sin(3.141592653589793 * k / 2048.0) + 0.5);
        end
        reset_n   = 1'b1;
        clken     = 1'b0;
        phi_inc_i = 32'd0;
        model_acc = 32'd0;
        exp_sin   = 0;
        exp_cos   = 0;
        exp_valid = 0;

        // Reset held 7 cycles, clken varying to show reset wins.
        phase = "reset";
        for (int c = 0; c < 7; c++) step(1'b1, c[0], 32'h4000_0000);

        // Quarter step; out_valid must rise on the 4th enabled edge.
        phase = "quarter";
        first_valid = 0;
        nvalid = 0;
        for (int c = 1; c <= 24; c++) begin
            step(1'b0, 1'b1, 32'h4000_0000);
            if (out_valid && first_valid == 0) first_valid = c;
            if (out_valid) begin
                check_val("pattern_sin", int'($signed(fsin_o)), quarter_sin[nvalid % 4]);
`ifdef NCO8M_COS_OUT_EN
                check_val("pattern_cos", int'($signed(fcos_o)), quarter_cos[nvalid % 4]);
`endif
                nvalid++;
            end
        end
        check_val("first_valid_edge", first_valid, 4);

        // Nominal ~8 MHz tone: 2000 valid samples plus peak check.
        phase = "nominal";
        step(1'b1, 1'b1, 32'd0);
        pmax = -1000;
        pmin = 1000;
        for (int c = 0; c < 2003; c++) begin
            step(1'b0, 1'b1, 32'h294A_5295);
            if (out_valid) begin
                if (int'($signed(fsin_o)) > pmax) pmax = int'($signed(fsin_o));
                if (int'($signed(fsin_o)) < pmin) pmin = int'($signed(fsin_o));
            end
        end
        check_val("peak_pos_ge_510", int'(pmax >= 510 && pmax <= 511), 1);
        check_val("peak_neg_le_m510", int'(pmin <= -510 && pmin >= -511), 1);

        // Zero increment: constant 0.
        phase = "zero";
        step(1'b1, 1'b1, 32'd0);
        for (int c = 0; c < 30; c++) step(1'b0, 1'b1, 32'd0);

        // Wrap-around increment: 0, -1, then decreasing.
        phase = "wrap";
        step(1'b1, 1'b1, 32'd0);
        nvalid = 0;
        for (int c = 0; c < 80; c++) begin
            step(1'b0, 1'b1, 32'hFFF0_0000);
            if (out_valid) begin
                if (nvalid == 0) check_val("wrap_first", int'($signed(fsin_o)), 0);
                if (nvalid == 1) check_val("wrap_second", int'($signed(fsin_o)), -1);
                nvalid++;
            end
        end

        // Random clken with a constant random increment.
        phase = "clken";
        inc = $urandom;
        step(1'b1, 1'b1, 32'd0);
        for (int c = 0; c < 600; c++) step(1'b0, 1'($urandom_range(0, 1)), inc);

        // Random clken with the increment changing every cycle.
        phase = "clken_inc";
        for (int c = 0; c < 300; c++) step(1'b0, 1'($urandom_range(0, 1)), $urandom);

        // Mid-run reset after 37 valid samples.
        phase = "midreset";
        inc = $urandom;
        step(1'b1, 1'b1, 32'd0);
        nvalid = 0;
        for (int c = 0; c < 200 && nvalid < 37; c++) begin
            step(1'b0, 1'b1, inc);
            if (out_valid) nvalid++;
        end
        check_val("samples_before_reset", nvalid, 37);
        step(1'b1, 1'b1, inc);
        check_val("cleared_valid", int'(out_valid), 0);
        check_val("cleared_fsin", int'($signed(fsin_o)), 0);
        for (int c = 0; c < 20; c++) step(1'b0, 1'b1, inc);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
